// File: rtl/swim_pkg.sv
// Shared SWIM definitions: FSM state encoding, frame sizes and default timing
// constants used by both the receive decoder and the transmit side.
package swim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FALL = 2'd1,
        ST_LOW       = 2'd2,
        ST_HIGH      = 2'd3
    } swim_rx_state_e;

    localparam int   SWIM_ACK_BITS   = 1;
    localparam int   SWIM_FRAME_BITS = 10;
    localparam logic FRAME_MODE_ACK  = 1'b0;
    localparam logic FRAME_MODE_DATA = 1'b1;

    // 11 SWIM clocks at 8 MHz seen from a 48 MHz system clock
    localparam int SWIM_THRESH_CYC  = 66;
    localparam int SWIM_TIMEOUT_CYC = 1024;

    function automatic logic swim_even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/swim_edge_sync.sv
// Two-flop synchronizer for the asynchronous SWIM pin plus a registered
// previous value, producing single-cycle rise/fall pulses.
module swim_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic swim_in,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = swim_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Idle line is high, so reset everything to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

endmodule

// File: rtl/swim_rx.sv
// SWIM receive decoder: pulse-width bit decode, ACK or 10-bit frame assembly,
// valid/ready result port. Optional glitch filter: SWIM_RX_GLITCH_FILTER_EN.
module swim_rx
    import swim_pkg::*;
#(
    parameter int THRESH_CYC  = SWIM_THRESH_CYC,
    parameter int TIMEOUT_CYC = SWIM_TIMEOUT_CYC,
    parameter int MIN_LOW_CYC = 3,
    parameter int CNT_W       = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       swim_in,
    input  logic       arm,
    input  logic       frame_mode,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       hdr_err,
    output logic       timeout,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH_CYC);
`ifdef SWIM_RX_GLITCH_FILTER_EN
    localparam int MIN_LOW_EFF = MIN_LOW_CYC;
`else
    localparam int MIN_LOW_EFF = MIN_LOW_CYC * 0;
`endif

    logic rise, fall;

    swim_edge_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .swim_in (swim_in),
        .rise    (rise),
        .fall    (fall)
    );

    swim_rx_state_e   state_q, state_d, ret_state_q, ret_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, cnt_inc;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [9:0]       shift_q, shift_d;
    logic             mode_q, mode_d, busy_q, busy_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
    logic             hdr_err_q, hdr_err_d, timeout_q, timeout_d, overrun_q, overrun_d;
    logic             consume, finish, abort, is_glitch;

    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        cnt_d        = cnt_q;
        saved_cnt_d  = saved_cnt_q;
        bits_left_d  = bits_left_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        busy_d       = busy_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        hdr_err_d    = hdr_err_q;
        timeout_d    = 1'b0;
        overrun_d    = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;
        // cnt_inc doubles as the low-pulse length: the fall-detect cycle is the first low cycle
        cnt_inc      = (cnt_q >= TMO) ? TMO : cnt_q + CNT_W'(1);
        is_glitch    = int'(cnt_inc) < MIN_LOW_EFF;
        consume      = rx_valid_q & rx_ready;

        if (consume) begin
            rx_valid_d   = 1'b0;
            parity_err_d = 1'b0;
            hdr_err_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    mode_d      = frame_mode;
                    bits_left_d = (frame_mode == FRAME_MODE_DATA) ? 4'(SWIM_FRAME_BITS)
                                                                  : 4'(SWIM_ACK_BITS);
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL, ST_HIGH: begin
                if (fall) begin
                    ret_state_d = state_q;
                    saved_cnt_d = cnt_q;
                    cnt_d       = '0;
                    state_d     = ST_LOW;
                end else if (cnt_inc >= TMO) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    if (is_glitch) begin
                        state_d = ret_state_q;
                        cnt_d   = saved_cnt_q;
                    end else begin
                        shift_d     = {shift_q[8:0], (cnt_inc < THR)};
                        bits_left_d = bits_left_q - 4'd1;
                        if (bits_left_q == 4'd1) begin
                            finish = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_HIGH;
                        end
                    end
                end else if (cnt_inc >= TMO) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
        end

        // A result already waiting and not taken this cycle wins over the new one.
        if (finish) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (!rx_valid_q || consume) begin
                rx_valid_d = 1'b1;
                if (mode_q == FRAME_MODE_DATA) begin
                    rx_data_d    = shift_d[8:1];
                    hdr_err_d    = ~shift_d[9];
                    parity_err_d = shift_d[0] != swim_even_parity(shift_d[8:1]);
                end else begin
                    rx_data_d    = {7'b0, shift_d[0]};
                    hdr_err_d    = 1'b0;
                    parity_err_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ret_state_q  <= ST_IDLE;
            cnt_q        <= '0;
            saved_cnt_q  <= '0;
            bits_left_q  <= '0;
            shift_q      <= '0;
            mode_q       <= FRAME_MODE_ACK;
            busy_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            hdr_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_state_q  <= ret_state_d;
            cnt_q        <= cnt_d;
            saved_cnt_q  <= saved_cnt_d;
            bits_left_q  <= bits_left_d;
            shift_q      <= shift_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            hdr_err_q    <= hdr_err_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy       = busy_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign hdr_err    = hdr_err_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_swim_rx.sv
// Directed + randomized bench for swim_rx; the reference model decodes a list
// of low-pulse widths straight from the SWIM bit rules.
module tb_swim_rx;

    localparam int THRESH  = 66;
    localparam int MIN_LOW = 3;
`ifdef SWIM_RX_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       swim_in = 1'b1;
    logic       arm = 1'b0;
    logic       frame_mode = 1'b0;
    logic       rx_ready = 1'b0;
    logic       busy, rx_valid, parity_err, hdr_err, timeout, overrun;
    logic [7:0] rx_data;

    swim_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .swim_in    (swim_in),
        .arm        (arm),
        .frame_mode (frame_mode),
        .busy       (busy),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .hdr_err    (hdr_err),
        .timeout    (timeout),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_tmo = 0;
    int n_ovr = 0;
    int rearm_idx = -1;
    logic [9:0] exp_q[$];
    int lows_q[$];
    int highs_q[$];

    always @(negedge clk) begin
        if (timeout) n_tmo++;
        if (overrun) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_bit(input logic b, input bit rnd);
        if (b) begin
            lows_q.push_back(rnd ? int'($urandom_range(3, 65)) : 12);
            highs_q.push_back(rnd ? int'($urandom_range(3, 40)) : 120);
        end else begin
            lows_q.push_back(rnd ? int'($urandom_range(66, 150)) : 120);
            highs_q.push_back(rnd ? int'($urandom_range(3, 40)) : 12);
        end
    endtask

    task automatic add_frame(input logic [9:0] f, input int nbits, input bit rnd);
        for (int i = nbits - 1; i >= 0; i--) add_bit(f[i], rnd);
    endtask

    // Expected {hdr_err, parity_err, rx_data} from the pulse list alone.
    function automatic logic [9:0] model(input logic mode);
        logic bits[$];
        logic [7:0] d;
        int need;
        need = mode ? 10 : 1;
        foreach (lows_q[i]) begin
            if (bits.size() < need && !(FILT && lows_q[i] < MIN_LOW))
                bits.push_back(lows_q[i] < THRESH);
        end
        if (!mode) return {9'b0, bits[0]};
        d = '0;
        for (int i = 1; i <= 8; i++) d = {d[6:0], bits[i]};
        return {~bits[0], bits[9] ^ (^d), d};
    endfunction

    task automatic arm_frame(input logic mode);
        arm = 1'b1;
        frame_mode = mode;
        cyc(1);
        arm = 1'b0;
        frame_mode = logic'($urandom_range(0, 1));
    endtask

    task automatic drive_pulses();
        foreach (lows_q[i]) begin
            swim_in = 1'b0;
            cyc(lows_q[i]);
            swim_in = 1'b1;
            if (i == rearm_idx) begin
                arm = 1'b1;
                frame_mode = 1'b0;
                cyc(1);
                arm = 1'b0;
                cyc(highs_q[i] - 1);
            end else begin
                cyc(highs_q[i]);
            end
        end
        cyc(8);
        rearm_idx = -1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !rx_valid; i++) cyc(1);
        check({tag, "_valid"}, rx_valid, 1);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        check({tag, "_clear"}, {rx_valid, parity_err, hdr_err}, 0);
    endtask

    task automatic frame(input string tag, input logic mode);
        logic [9:0] e;
        exp_q.push_back(model(mode));
        arm_frame(mode);
        drive_pulses();
        wait_valid(tag);
        e = exp_q.pop_front();
        check(tag, {hdr_err, parity_err, rx_data}, e);
        check({tag, "_busy"}, busy, 0);
        lows_q.delete();
        highs_q.delete();
    endtask

    task automatic wait_timeout(input string tag, input int base, output int waited);
        waited = 0;
        while (n_tmo == base && waited < 1200) begin
            cyc(1);
            waited++;
        end
        check({tag, "_pulse"}, n_tmo - base, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_novalid"}, rx_valid, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       h, p;
        int         base, waited;

        cyc(3);
        check("rst_in_reset", {busy, rx_valid, rx_data, parity_err, hdr_err, timeout, overrun}, 0);
        reset_n = 1'b1;
        cyc(2);
        check("rst_after", {busy, rx_valid, rx_data, parity_err, hdr_err, timeout, overrun}, 0);

        // 0xA5 with a stray arm mid-frame that must be ignored
        add_frame({1'b1, 8'hA5, 1'b0}, 10, 1'b0);
        rearm_idx = 3;
        frame("a5", 1'b1);
        check("a5_exact", {hdr_err, parity_err, rx_data}, {2'b00, 8'hA5});
        consume("a5");

        add_frame(10'd1, 1, 1'b0);
        frame("ack1", 1'b0);
        check("ack1_exact", rx_data, 8'h01);
        consume("ack1");
        add_frame(10'd0, 1, 1'b0);
        frame("ack0", 1'b0);
        check("ack0_exact", rx_data, 8'h00);
        consume("ack0");

        lows_q.push_back(THRESH - 1);
        highs_q.push_back(20);
        frame("thr_minus1", 1'b0);
        consume("thr_minus1");
        lows_q.push_back(THRESH);
        highs_q.push_back(20);
        frame("thr_exact", 1'b0);
        consume("thr_exact");

        add_frame({1'b1, 8'hA5, 1'b1}, 10, 1'b0);
        frame("par_err", 1'b1);
        check("par_err_exact", {hdr_err, parity_err, rx_data}, {2'b01, 8'hA5});
        consume("par_err");
        add_frame({1'b0, 8'hA5, 1'b0}, 10, 1'b0);
        frame("hdr_err", 1'b1);
        check("hdr_err_exact", {hdr_err, parity_err, rx_data}, {2'b10, 8'hA5});
        consume("hdr_err");

        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            h = ($urandom_range(0, 3) != 0);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            add_frame({h, d, p}, 10, 1'b1);
            frame("rnd_data", 1'b1);
            consume("rnd_data");
        end
        for (int k = 0; k < 4; k++) begin
            add_frame({9'b0, logic'($urandom_range(0, 1))}, 1, 1'b1);
            frame("rnd_ack", 1'b0);
            consume("rnd_ack");
        end

        // 2-cycle low between data bits
        add_frame({1'b1, 8'hA5, 1'b0}, 10, 1'b0);
        lows_q.insert(5, 2);
        highs_q.insert(5, 6);
        frame("glitch", 1'b1);
        consume("glitch");

        // Backpressure: second frame dropped, first kept
        add_frame({1'b1, 8'h3C, 1'b0}, 10, 1'b1);
        frame("bp_first", 1'b1);
        base = n_ovr;
        add_frame({1'b1, 8'h81, 1'b0}, 10, 1'b1);
        arm_frame(1'b1);
        drive_pulses();
        lows_q.delete();
        highs_q.delete();
        cyc(5);
        check("bp_overrun", n_ovr - base, 1);
        check("bp_keep", {rx_valid, rx_data}, {1'b1, 8'h3C});
        consume("bp");

        // Line idles high after arm
        base = n_tmo;
        arm_frame(1'b1);
        wait_timeout("tmo_high", base, waited);
        check("tmo_high_time", (waited >= 1020 && waited <= 1030), 1);

        // Line stuck low mid-frame
        base = n_tmo;
        add_frame({1'b1, 8'hFF, 1'b0}, 3, 1'b1);
        arm_frame(1'b1);
        foreach (lows_q[i]) begin
            swim_in = 1'b0;
            cyc(lows_q[i]);
            swim_in = 1'b1;
            cyc(highs_q[i]);
        end
        lows_q.delete();
        highs_q.delete();
        swim_in = 1'b0;
        wait_timeout("tmo_low", base, waited);
        swim_in = 1'b1;
        cyc(10);

        // Reset mid-frame
        arm_frame(1'b1);
        swim_in = 1'b0;
        cyc(20);
        swim_in = 1'b1;
        cyc(20);
        reset_n = 1'b0;
        cyc(1);
        check("rst_mid", {busy, rx_valid, timeout}, 0);
        reset_n = 1'b1;
        cyc(3);
        add_frame({1'b1, 8'h5A, 1'b0}, 10, 1'b1);
        frame("after_rst", 1'b1);
        consume("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
